// File: rtl/flow_ram_arbiter.sv
// Two-client arbiter for the flow RAM read/write ports: client 0 has priority with a
// starvation bound for client 1; read responses are steered back via an in-order tag FIFO.
module flow_ram_arbiter #(
  parameter int ADDR_WIDTH     = 16,
  parameter int WORD_WIDTH     = 32,
  parameter int TAG_DEPTH_BITS = 6,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  c0_rd_req,
  input  logic [ADDR_WIDTH-1:0] c0_rd_addr,
  output logic                  c0_rd_ack,
  output logic [WORD_WIDTH-1:0] c0_rd_data,
  output logic                  c0_rd_valid,
  input  logic                  c0_wr_req,
  input  logic [ADDR_WIDTH-1:0] c0_wr_addr,
  input  logic [WORD_WIDTH-1:0] c0_wr_data,
  output logic                  c0_wr_ack,
  input  logic                  c1_rd_req,
  input  logic [ADDR_WIDTH-1:0] c1_rd_addr,
  output logic                  c1_rd_ack,
  output logic [WORD_WIDTH-1:0] c1_rd_data,
  output logic                  c1_rd_valid,
  input  logic                  c1_wr_req,
  input  logic [ADDR_WIDTH-1:0] c1_wr_addr,
  input  logic [WORD_WIDTH-1:0] c1_wr_data,
  output logic                  c1_wr_ack,
  output logic                  ram_read_en,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic                  ram_read_ready,
  input  logic [WORD_WIDTH-1:0] ram_read_data,
  input  logic                  ram_read_data_new,
  output logic                  ram_write_en,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [WORD_WIDTH-1:0] ram_write_data,
  input  logic                  ram_write_ready
);

  localparam int DEPTH = 1 << TAG_DEPTH_BITS;
  localparam int SW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]             STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TAG_DEPTH_BITS:0]   OUT_FULL   = (TAG_DEPTH_BITS + 1)'(DEPTH);

  typedef enum logic {IDLE, HOLD} state_t;

  function automatic logic [SW-1:0] starve_next(input logic [SW-1:0] cnt, input logic c1_req,
                                                input logic issue, input logic sel);
    if (!c1_req || (issue && sel)) return '0;
    if (issue && cnt != STARVE_MAX) return cnt + 1'b1;
    return cnt;
  endfunction

  state_t              rd_state, rd_state_nxt, wr_state, wr_state_nxt;
  logic                rd_sel_q, rd_sel, rd_en, rd_issue, rd_block, rd_pop, rd_head;
  logic                wr_sel_q, wr_sel, wr_en, wr_issue;
  logic [SW-1:0]       rd_starve, wr_starve;
  logic [TAG_DEPTH_BITS:0]   rd_outstanding;
  logic [TAG_DEPTH_BITS-1:0] tag_wr_ptr, tag_rd_ptr;
  logic [DEPTH-1:0]    tag_mem;
  logic                err_underflow;

  // A full tag FIFO blocks new reads unless a tag is popped in the same cycle.
  assign rd_block = (rd_outstanding == OUT_FULL) && !ram_read_data_new;
  assign rd_pop   = ram_read_data_new && (rd_outstanding != '0);
  assign rd_head  = tag_mem[tag_rd_ptr];
  assign rd_issue = rd_en && ram_read_ready;
  assign wr_issue = wr_en && ram_write_ready;

  always_comb begin
    rd_state_nxt = rd_state;
    rd_sel       = rd_sel_q;
    rd_en        = 1'b0;
    case (rd_state)
      IDLE: begin
        if (!rd_block && (c0_rd_req || c1_rd_req)) begin
          rd_en  = 1'b1;
          rd_sel = c1_rd_req && (!c0_rd_req || rd_starve == STARVE_MAX);
          if (!ram_read_ready) rd_state_nxt = HOLD;
        end
      end
      HOLD: begin
        rd_en = 1'b1;
        if (ram_read_ready) rd_state_nxt = IDLE;
      end
      default: rd_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr_state_nxt = wr_state;
    wr_sel       = wr_sel_q;
    wr_en        = 1'b0;
    case (wr_state)
      IDLE: begin
        if (c0_wr_req || c1_wr_req) begin
          wr_en  = 1'b1;
          wr_sel = c1_wr_req && (!c0_wr_req || wr_starve == STARVE_MAX);
          if (!ram_write_ready) wr_state_nxt = HOLD;
        end
      end
      HOLD: begin
        wr_en = 1'b1;
        if (ram_write_ready) wr_state_nxt = IDLE;
      end
      default: wr_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_state       <= IDLE;
      rd_sel_q       <= 1'b0;
      rd_starve      <= '0;
      wr_state       <= IDLE;
      wr_sel_q       <= 1'b0;
      wr_starve      <= '0;
      rd_outstanding <= '0;
      tag_wr_ptr     <= '0;
      tag_rd_ptr     <= '0;
      err_underflow  <= 1'b0;
    end else begin
      rd_state       <= rd_state_nxt;
      rd_sel_q       <= rd_sel;
      rd_starve      <= starve_next(rd_starve, c1_rd_req, rd_issue, rd_sel);
      wr_state       <= wr_state_nxt;
      wr_sel_q       <= wr_sel;
      wr_starve      <= starve_next(wr_starve, c1_wr_req, wr_issue, wr_sel);
      rd_outstanding <= rd_outstanding + {{TAG_DEPTH_BITS{1'b0}}, rd_issue}
                                       - {{TAG_DEPTH_BITS{1'b0}}, rd_pop};
      if (rd_issue) tag_wr_ptr <= tag_wr_ptr + 1'b1;
      if (rd_pop)   tag_rd_ptr <= tag_rd_ptr + 1'b1;
      if (ram_read_data_new && rd_outstanding == '0) err_underflow <= 1'b1;
    end
  end

  // Tag storage carries no reset; the pointers alone define its contents.
  always_ff @(posedge clk) begin
    if (rd_issue) tag_mem[tag_wr_ptr] <= rd_sel;
  end

  assign ram_read_en    = reset && rd_en;
  assign ram_read_addr  = !ram_read_en ? '0 : (rd_sel ? c1_rd_addr : c0_rd_addr);
  assign c0_rd_ack      = reset && rd_issue && !rd_sel;
  assign c1_rd_ack      = reset && rd_issue && rd_sel;
  assign c0_rd_valid    = reset && rd_pop && !rd_head;
  assign c1_rd_valid    = reset && rd_pop && rd_head;
  assign c0_rd_data     = reset ? ram_read_data : '0;
  assign c1_rd_data     = reset ? ram_read_data : '0;

  assign ram_write_en   = reset && wr_en;
  assign ram_write_addr = !ram_write_en ? '0 : (wr_sel ? c1_wr_addr : c0_wr_addr);
  assign ram_write_data = !ram_write_en ? '0 : (wr_sel ? c1_wr_data : c0_wr_data);
  assign c0_wr_ack      = reset && wr_issue && !wr_sel;
  assign c1_wr_ack      = reset && wr_issue && wr_sel;

endmodule

// File: tb/tb_flow_ram_arbiter.sv
// Directed bench for flow_ram_arbiter: vector table for steady-state arbitration and
// hand-written sequences for hold, full, underflow and reset behaviour.
module tb_flow_ram_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        c0_rd_req, c1_rd_req, c0_wr_req, c1_wr_req;
  logic [15:0] c0_rd_addr, c1_rd_addr, c0_wr_addr, c1_wr_addr;
  logic [31:0] c0_wr_data, c1_wr_data;
  logic        c0_rd_ack, c1_rd_ack, c0_wr_ack, c1_wr_ack, c0_rd_valid, c1_rd_valid;
  logic [31:0] c0_rd_data, c1_rd_data;
  logic        ram_read_en, ram_read_ready, ram_read_data_new;
  logic [15:0] ram_read_addr, ram_write_addr;
  logic [31:0] ram_read_data, ram_write_data;
  logic        ram_write_en, ram_write_ready;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  flow_ram_arbiter #(.ADDR_WIDTH(16), .WORD_WIDTH(32), .TAG_DEPTH_BITS(6), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .c0_rd_req(c0_rd_req), .c0_rd_addr(c0_rd_addr), .c0_rd_ack(c0_rd_ack),
    .c0_rd_data(c0_rd_data), .c0_rd_valid(c0_rd_valid),
    .c0_wr_req(c0_wr_req), .c0_wr_addr(c0_wr_addr), .c0_wr_data(c0_wr_data), .c0_wr_ack(c0_wr_ack),
    .c1_rd_req(c1_rd_req), .c1_rd_addr(c1_rd_addr), .c1_rd_ack(c1_rd_ack),
    .c1_rd_data(c1_rd_data), .c1_rd_valid(c1_rd_valid),
    .c1_wr_req(c1_wr_req), .c1_wr_addr(c1_wr_addr), .c1_wr_data(c1_wr_data), .c1_wr_ack(c1_wr_ack),
    .ram_read_en(ram_read_en), .ram_read_addr(ram_read_addr), .ram_read_ready(ram_read_ready),
    .ram_read_data(ram_read_data), .ram_read_data_new(ram_read_data_new),
    .ram_write_en(ram_write_en), .ram_write_addr(ram_write_addr), .ram_write_data(ram_write_data),
    .ram_write_ready(ram_write_ready)
  );

  typedef struct {
    logic c0r; logic [15:0] c0a; logic c1r; logic [15:0] c1a; logic rrdy; logic dn; logic [31:0] rd;
    logic w0r; logic [15:0] w0a; logic w1r; logic [15:0] w1a; logic wrdy;
    logic ea0; logic ea1; logic een; logic [15:0] eaddr; logic ev0; logic ev1;
    logic ewa0; logic ewa1; logic ewen; logic [15:0] ewaddr; logic [31:0] ewdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic c0r, input logic [15:0] c0a, input logic c1r,
                              input logic [15:0] c1a, input logic dn, input logic [31:0] rd,
                              input logic ea0, input logic ea1, input logic [15:0] eaddr,
                              input logic ev0, input logic ev1);
    vec_t v;
    v.c0r = c0r; v.c0a = c0a; v.c1r = c1r; v.c1a = c1a; v.rrdy = 1'b1; v.dn = dn; v.rd = rd;
    v.w0r = 1'b0; v.w0a = '0; v.w1r = 1'b0; v.w1a = '0; v.wrdy = 1'b1;
    v.ea0 = ea0; v.ea1 = ea1; v.een = ea0 | ea1; v.eaddr = eaddr; v.ev0 = ev0; v.ev1 = ev1;
    v.ewa0 = 1'b0; v.ewa1 = 1'b0; v.ewen = 1'b0; v.ewaddr = '0; v.ewdata = '0;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic idle_inputs();
    c0_rd_req = 0; c1_rd_req = 0; c0_wr_req = 0; c1_wr_req = 0;
    c0_rd_addr = '0; c1_rd_addr = '0; c0_wr_addr = '0; c1_wr_addr = '0;
    c0_wr_data = '0; c1_wr_data = '0;
    ram_read_ready = 1; ram_write_ready = 1; ram_read_data_new = 0; ram_read_data = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, " acks"}, {c0_rd_ack, c1_rd_ack, c0_wr_ack, c1_wr_ack}, 0);
    check({nm, " valids"}, {c0_rd_valid, c1_rd_valid}, 0);
    check({nm, " rd bus"}, {ram_read_en, ram_read_addr}, 0);
    check({nm, " wr bus"}, {ram_write_en, ram_write_addr, ram_write_data}, 0);
    check({nm, " rd data"}, {c0_rd_data, c1_rd_data}, 0);
  endtask

  initial begin
    vec_t v;
    int   acks;
    int   vals;
    logic g, t;

    // Single client: three back-to-back reads, then returns 5 cycles after the first issue.
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 16'h10 + 16'(i), 0, 0, 0, 0, 1, 0, 16'h10 + 16'(i), 0, 0));
    for (int i = 0; i < 2; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, 0, 1, 32'hA0 + 32'(i), 0, 0, 0, 1, 0));
    // Starvation on both paths at once: c0 x4, c1 x1, repeated.
    for (int i = 0; i < 10; i++) begin
      g = (i % 5 == 4);
      v = mk(1, 16'h20, 1, 16'h30, 0, 0, !g, g, g ? 16'h30 : 16'h20, 0, 0);
      v.w0r = 1; v.w0a = 16'h50; v.w1r = 1; v.w1a = 16'h60;
      v.ewa0 = !g; v.ewa1 = g; v.ewen = 1; v.ewaddr = g ? 16'h60 : 16'h50;
      v.ewdata = g ? 32'hD000_0060 : 32'hC000_0050;
      vecs.push_back(v);
    end
    for (int i = 0; i < 10; i++) begin
      t = (i % 5 == 4);
      vecs.push_back(mk(0, 0, 0, 0, 1, 32'h200 + 32'(i), 0, 0, 0, !t, t));
    end
    // Interleaved issues c0,c1,c1,c0 and their in-order returns.
    for (int i = 0; i < 4; i++) begin
      t = (i == 1 || i == 2);
      vecs.push_back(mk(!t, 16'h40 + 16'(i), t, 16'h40 + 16'(i), 0, 0, !t, t, 16'h40 + 16'(i), 0, 0));
    end
    for (int i = 0; i < 4; i++) begin
      t = (i == 1 || i == 2);
      vecs.push_back(mk(0, 0, 0, 0, 1, 32'hD0 + 32'(i), 0, 0, 0, !t, t));
    end

    // Reset with requests and a stray return present: outputs must be forced low.
    idle_inputs();
    reset = 0;
    c0_rd_req = 1; c1_wr_req = 1; ram_read_data_new = 1; ram_read_data = 32'hDEAD;
    tick(); tick();
    @(negedge clk);
    check_all_zero("initial reset");
    tick();
    idle_inputs();
    reset = 1;
    tick();

    foreach (vecs[i]) begin
      v = vecs[i];
      c0_rd_req = v.c0r; c0_rd_addr = v.c0a; c1_rd_req = v.c1r; c1_rd_addr = v.c1a;
      ram_read_ready = v.rrdy; ram_read_data_new = v.dn; ram_read_data = v.rd;
      c0_wr_req = v.w0r; c0_wr_addr = v.w0a; c0_wr_data = {16'hC000, v.w0a};
      c1_wr_req = v.w1r; c1_wr_addr = v.w1a; c1_wr_data = {16'hD000, v.w1a};
      ram_write_ready = v.wrdy;
      @(negedge clk);
      check($sformatf("v%0d rd acks", i), {c0_rd_ack, c1_rd_ack}, {v.ea0, v.ea1});
      check($sformatf("v%0d rd en", i), ram_read_en, v.een);
      if (v.een) check($sformatf("v%0d rd addr", i), ram_read_addr, v.eaddr);
      check($sformatf("v%0d valids", i), {c0_rd_valid, c1_rd_valid}, {v.ev0, v.ev1});
      if (v.ev0) check($sformatf("v%0d c0 data", i), c0_rd_data, v.rd);
      if (v.ev1) check($sformatf("v%0d c1 data", i), c1_rd_data, v.rd);
      check($sformatf("v%0d wr acks", i), {c0_wr_ack, c1_wr_ack}, {v.ewa0, v.ewa1});
      check($sformatf("v%0d wr en", i), ram_write_en, v.ewen);
      if (v.ewen) check($sformatf("v%0d wr bus", i), {ram_write_addr, ram_write_data}, {v.ewaddr, v.ewdata});
      tick();
    end
    idle_inputs();

    // Backpressure: c1 locked through three not-ready cycles while c0 arrives.
    c1_rd_req = 1; c1_rd_addr = 16'h33; ram_read_ready = 0;
    @(negedge clk);
    check("bp c1 select", {ram_read_en, ram_read_addr, c0_rd_ack, c1_rd_ack}, {1'b1, 16'h33, 2'b00});
    tick();
    c0_rd_req = 1; c0_rd_addr = 16'h22;
    @(negedge clk);
    check("bp hold 2", {ram_read_en, ram_read_addr, c0_rd_ack, c1_rd_ack}, {1'b1, 16'h33, 2'b00});
    tick();
    @(negedge clk);
    check("bp hold 3", {ram_read_en, ram_read_addr, c0_rd_ack, c1_rd_ack}, {1'b1, 16'h33, 2'b00});
    tick();
    ram_read_ready = 1;
    @(negedge clk);
    check("bp c1 issue", {ram_read_en, ram_read_addr, c0_rd_ack, c1_rd_ack}, {1'b1, 16'h33, 2'b01});
    tick();
    c1_rd_req = 0;
    @(negedge clk);
    check("bp c0 next", {ram_read_addr, c0_rd_ack, c1_rd_ack}, {16'h22, 2'b10});
    tick();
    c0_rd_req = 0; ram_read_data_new = 1; ram_read_data = 32'hBB1;
    @(negedge clk);
    check("bp ret c1", {c0_rd_valid, c1_rd_valid, c1_rd_data}, {2'b01, 32'hBB1});
    tick();
    ram_read_data = 32'hBB0;
    @(negedge clk);
    check("bp ret c0", {c0_rd_valid, c1_rd_valid, c0_rd_data}, {2'b10, 32'hBB0});
    tick();
    idle_inputs();

    // Full: 64 reads with no returns, the 65th waits until a return pops a tag.
    c0_rd_req = 1;
    acks = 0;
    for (int i = 0; i < 64; i++) begin
      c0_rd_addr = 16'(i);
      @(negedge clk);
      if (c0_rd_ack) acks++;
      tick();
    end
    check("full 64 acks", 64'(acks), 64);
    c0_rd_addr = 16'h99;
    @(negedge clk);
    check("full blocked", {ram_read_en, c0_rd_ack}, 2'b00);
    tick();
    ram_read_data_new = 1; ram_read_data = 32'hF00;
    @(negedge clk);
    check("full issue on pop", {c0_rd_ack, ram_read_addr, c0_rd_valid}, {1'b1, 16'h99, 1'b1});
    tick();
    c0_rd_req = 0; ram_read_data_new = 0;
    @(negedge clk);
    check("full outstanding", 64'(dut.rd_outstanding), 64);
    tick();
    ram_read_data_new = 1;
    vals = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (c0_rd_valid && !c1_rd_valid) vals++;
      tick();
    end
    check("full drain valids", 64'(vals), 64);
    @(negedge clk);
    check("underflow ignored", {c0_rd_valid, c1_rd_valid}, 2'b00);
    tick();
    ram_read_data_new = 0;
    @(negedge clk);
    check("underflow flag", dut.err_underflow, 1);
    idle_inputs();
    tick();

    // Reset with 10 reads outstanding and a write stuck in HOLD.
    c0_rd_req = 1;
    for (int i = 0; i < 10; i++) begin
      c0_rd_addr = 16'h100 + 16'(i);
      tick();
    end
    c0_rd_req = 0;
    c1_wr_req = 1; c1_wr_addr = 16'h77; c1_wr_data = 32'h7777; ram_write_ready = 0;
    @(negedge clk);
    check("pre-reset wr hold", {ram_write_en, ram_write_addr, c1_wr_ack}, {1'b1, 16'h77, 1'b0});
    tick();
    reset = 0; c0_rd_req = 1; ram_read_data_new = 1; ram_write_ready = 1;
    tick();
    @(negedge clk);
    check_all_zero("mid reset");
    check("reset underflow clr", dut.err_underflow, 0);
    tick();
    idle_inputs();
    reset = 1;
    ram_read_data_new = 1;
    @(negedge clk);
    check("post-reset tags dropped", {c0_rd_valid, c1_rd_valid}, 2'b00);
    tick();
    ram_read_data_new = 0;
    c1_rd_req = 1; c1_rd_addr = 16'h5; c1_wr_req = 1; c1_wr_addr = 16'h6; c1_wr_data = 32'h66;
    @(negedge clk);
    check("post-reset rd ack", {c1_rd_ack, ram_read_addr}, {1'b1, 16'h5});
    check("post-reset wr ack", {c1_wr_ack, ram_write_addr, ram_write_data}, {1'b1, 16'h6, 32'h66});
    check("post-reset underflow", dut.err_underflow, 1);
    tick();
    idle_inputs();
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/flow_ram_arbiter.md
# flow_ram_arbiter

Shares one flow RAM simplified read/write interface between two requesters: client 0, the packet-path flow update engine, and client 1, the flow timeout scanner. Reads and writes are arbitrated independently. Client 0 has priority, and a starvation limit guarantees service to client 1. Read responses, which return in issue order, are routed back to the issuing client through a tag FIFO. The block sits between the flow engines and the SRAM interface module.

## Interface
Parameters:
- ADDR_WIDTH, `FLOW_RAM_ADDR_WIDTH`, flow RAM word address width.
- WORD_WIDTH, `FLOW_RAM_WORD_WIDTH`, flow RAM word width.
- TAG_DEPTH_BITS, 6, log2 of the maximum outstanding reads (matches the concurrent-request depth of the SRAM interface).
- STARVE_LIMIT, 4, the maximum number of consecutive client-0 grants while client 1 waits (per path).

Ports (K = 0, 1):
- clk  in  1  the single clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- cK_rd_req  in  1  client K read request; held with its address until acked.
- cK_rd_addr  in  ADDR_WIDTH  read address.
- cK_rd_ack  out  1  one-cycle pulse: the request was issued downstream this cycle.
- cK_rd_data  out  WORD_WIDTH  read data (shared bus, valid only with cK_rd_valid).
- cK_rd_valid  out  1  one-cycle pulse: the read data belongs to client K.
- cK_wr_req, cK_wr_addr, cK_wr_data, cK_wr_ack  write equivalents of the read signals above.
- ram_read_en  out  1; ram_read_addr  out  ADDR_WIDTH; ram_read_ready  in  1.
- ram_read_data  in  WORD_WIDTH; ram_read_data_new  in  1.
- ram_write_en  out  1; ram_write_addr  out  ADDR_WIDTH; ram_write_data  out  WORD_WIDTH; ram_write_ready  in  1.

## Operation
- The read path and write path each run an identical FSM: IDLE and HOLD.
- IDLE, selection:
  - If one client requests, that client is selected.
  - If both request, client 0 is selected unless starve_cnt == STARVE_LIMIT; then client 1 is selected.
  - A selected request drives ram_*_en with the selected address and data in the same cycle.
  - If ram_*_ready=1, the request issues: pulse cK_*_ack and stay in IDLE.
  - Otherwise latch the selection into a sel register and go to HOLD.
- HOLD:
  - Keep ram_*_en=1, with address and data taken from the locked client's inputs.
  - No re-arbitration happens in HOLD.
  - On ram_*_ready=1, issue and ack, then return to IDLE.
  - Clients must keep req, addr and data stable until ack.
- starve_cnt (per path, 0..STARVE_LIMIT):
  - Increments on a client-0 issue while c1 req=1.
  - Clears on any client-1 issue, or when c1 req=0.
  - Saturates at STARVE_LIMIT.
- Read gating: no read is selected in IDLE while outstanding == 2^TAG_DEPTH_BITS.
- Tag FIFO:
  - Depth 2^TAG_DEPTH_BITS, 1 bit wide.
  - Push the client id on each read issue; pop on ram_read_data_new.
  - The head selects the destination: cK_rd_valid = ram_read_data_new && head==K.
  - cK_rd_data = ram_read_data, passed combinationally.
- outstanding counter, width TAG_DEPTH_BITS+1:
  - +1 on issue, -1 on data_new, unchanged when both occur in the same cycle.
  - ram_read_data_new with outstanding==0 is a protocol error: it is ignored, and the sticky internal flag err_underflow is set.
- The read and write paths are independent: the same or different clients can be granted on both paths in the same cycle. Read/write address coherency is the clients' responsibility.

## Timing
- Reset (reset=0 at a rising edge):
  - Both FSMs go to IDLE; starve_cnt=0, outstanding=0, tag FIFO emptied, err_underflow=0.
  - All outputs are 0: acks, valids, ram_*_en, addresses, data.
  - Reset mid-operation drops in-flight tags; any later ram_read_data_new follows the underflow rule.
- Issue latency:
  - With ram_*_ready=1, request-to-ack is 0 cycles; ack is combinational from req and ready.
  - Ack lands in the same cycle as ram_*_en && ram_*_ready.
- Return latency: cK_rd_valid is in the same cycle as ram_read_data_new, with zero added latency.
- Ordering: responses to each client arrive in that client's issue order.
- Full boundary: when outstanding reaches 64 (default), the next read waits. It may issue in the same cycle that a data_new pops a tag.
- One issue per path per cycle at most; sustained throughput is 1 read + 1 write per cycle.

## Test plan
- Single client: c0 reads addresses 0x10, 0x11, 0x12 on consecutive cycles with ready=1 -> 3 acks in the same cycles; data returned 5 cycles later arrives on c0_rd_valid in order; c1_rd_valid stays 0.
- Starvation: both clients request reads continuously -> grant pattern c0,c0,c0,c0,c1 repeating; starve_cnt never exceeds 4.
- Backpressure: ram_read_ready=0 for 3 cycles while c1 is selected, c0 asserts mid-hold -> c1 stays locked (address stable), c1 is acked in the 4th cycle, then c0 is granted.
- Full: issue 64 reads with no returns -> 65th request not acked; one data_new -> 65th acks in that same cycle, and outstanding stays 64.
- Interleaved returns: issues c0,c1,c1,c0 with data D0..D3 -> valids c0(D0), c1(D1), c1(D2), c0(D3).
- Reset: assert reset with 10 reads outstanding and a write in HOLD -> all outputs 0 next cycle; after release the first request is acked normally.
